pipeline_consumer_fsm: RTL and testbench
========================================

# pipeline_consumer_fsm

Downstream sink for the two-lane global-stall pipeline. It consumes the output beats of pipeline 1 and pipeline 2, checks each lane against an expected incrementing sequence, and counts matches and errors. It is also the single source of `global_stall`, which freezes the producer and both pipelines. Stalls come from a pseudo-random LFSR back-pressure pattern or from an error halt.

## Interface
Parameters:
- `WIDTH`, 32: data width per lane.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `STALL_THRESH`, 4: stall chance per RUN cycle, in sixteenths (0 to 16).
- `CNT_W`, 16: width of the match and error counters.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_data_1`, in, WIDTH: lane-1 data.
- `in_valid_1`, in, 1: lane-1 beat valid.
- `in_flush_1`, in, 1: lane-1 flush marker.
- `in_data_2`, `in_valid_2`, `in_flush_2`: lane 2, same widths and meanings as lane 1.
- `stall_en`, in, 1: enables random back-pressure.
- `halt_on_error`, in, 1: enables entering HALT on a mismatch.
- `global_stall`, out, 1: registered stall to all upstream stages.
- `match_count`, out, CNT_W: total matching beats across both lanes.
- `err_count`, out, CNT_W: total mismatching beats across both lanes.
- `error_flag`, out, 1: sticky; set on the first mismatch.
- `halted`, out, 1: high while in HALT.

## Operation
- Reset is synchronous, active-high. All outputs and internal state take their reset values on the next edge.
  - Reset values: `global_stall`=0, `match_count`=0, `err_count`=0, `error_flag`=0, `halted`=0.
  - Internal state at reset: state=RUN, lfsr=`LFSR_SEED`, `exp_1`=1, `exp_2`=2, resync flags=0, stall counter=0.
  - Reset overrides every other event, including HALT and an active stall.
- Accept rule, per lane: a beat is accepted when `in_valid_x`=1 and `global_stall`=0, using the current registered value of `global_stall`.
  - When `global_stall`=1, lane inputs are ignored and no counter or expected value changes.
- Flush rule: if `in_flush_x`=1 while `global_stall`=0, the beat is discarded and never counted, even if `in_valid_x`=1.
  - The flush sets `resync_x`.
  - The next accepted beat on that lane loads `exp_x`=data+1, increments `match_count`, and clears `resync_x`.
- Check rule, for an accepted beat that is not a resync beat:
  - If data == `exp_x`: `match_count`+1.
  - Otherwise: `err_count`+1, and `error_flag` is set.
  - In both cases `exp_x` becomes data+1. This resyncs after an error, so one bad beat produces exactly one error.
- Arithmetic:
  - `exp_x` increments modulo 2^WIDTH (all-ones wraps to 0 and is not an error).
  - Both counters saturate at 2^CNT_W−1.
  - Two same-kind events in one cycle add 2; saturation is still respected (all-ones−1 plus 2 gives all-ones).
- LFSR: 16-bit Galois, mask 16'hB400, shift right. It advances every cycle out of reset, in every state.
- State machine (RUN, STALL, HALT):
  - RUN, `global_stall`=0:
    - If a mismatch occurs this cycle and `halt_on_error`=1, go to HALT.
    - Else, if `stall_en`=1 and lfsr[3:0] < `STALL_THRESH`, go to STALL and load stall counter = lfsr[6:4]+1 (1 to 8).
    - Otherwise stay in RUN.
  - STALL, `global_stall`=1: decrement the counter each cycle; when it reaches 1, return to RUN.
    - Every stall lasts exactly the loaded number of cycles.
    - RUN always lasts at least 1 cycle between stalls.
  - HALT, `global_stall`=1, `halted`=1: terminal; only `reset` leaves it.
- Priority in RUN: halt over stall. `STALL_THRESH`=0 never stalls; 16 stalls after every RUN cycle.

## Timing
- `global_stall`, `halted`, the counters and `error_flag` are registered. Each reflects an accepted beat or state decision on the edge that ends that cycle, so outputs change one cycle after the beat.
- `global_stall` rises on the same edge the FSM enters STALL or HALT, and falls on the edge it returns to RUN.
- No combinational path from any input to any output.
- Lanes are independent. Simultaneous valid, flush, match or error on both lanes in one cycle are all applied in that cycle.
- Reset mid-stall: `global_stall`=0 on the edge after reset is sampled high.

## Test plan
- Reset check: hold reset 2 cycles, release. All outputs 0, `halted`=0, and `global_stall` stays 0 with `stall_en`=0.
- In-order stream: `stall_en`=0; feed (1,2), (2,3), (3,4) valid on both lanes. `match_count`=6, `err_count`=0, `error_flag`=0.
- Mismatch and resync: after (1,2), feed lane-1 data 7 with lane 2 = 3, then (8,4).
  - Result: `err_count`=1, `match_count`=5, `error_flag`=1, `halted`=0.
- Flush: after (1,2), assert `in_flush_1` with `in_valid_1`=1 and data 99, then lane-1 data 50, then 51.
  - Result: the flushed beat is not counted; 50 is a resync match; 51 matches; no errors.
- Halt: `halt_on_error`=1; feed a lane-2 mismatch.
  - Next cycle `global_stall`=1 and `halted`=1; both stay high for 20 cycles, and beats are ignored.
  - Reset clears both.
- Random stall: `stall_en`=1, `STALL_THRESH`=16, default seed.
  - Every stall burst lasts 1 to 8 cycles and matches the LFSR model; exactly 1 RUN cycle separates bursts.
  - Beats presented while `global_stall`=1 never change the counters.

Source files
------------

// File: rtl/pipeline_consumer_fsm.sv
// rtl/pipeline_consumer_fsm.sv - two-lane sequence checker and global stall source
module pipeline_consumer_fsm #(
    parameter int          WIDTH        = 32,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          STALL_THRESH = 4,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data_1,
    input  logic             in_valid_1,
    input  logic             in_flush_1,
    input  logic [WIDTH-1:0] in_data_2,
    input  logic             in_valid_2,
    input  logic             in_flush_2,
    input  logic             stall_en,
    input  logic             halt_on_error,
    output logic             global_stall,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count,
    output logic             error_flag,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Threshold widened so that 16 (always stall) is representable.
    localparam logic [4:0] THRESH = 5'(STALL_THRESH);

    state_t           state, state_nxt;
    logic [15:0]      lfsr;
    logic [3:0]       stall_cnt, stall_cnt_nxt;
    logic [WIDTH-1:0] exp_1, exp_2;
    logic             resync_1, resync_2;

    logic             acc_1, acc_2;
    logic             flush_1, flush_2;
    logic             match_1, match_2;
    logic             err_1, err_2;
    logic             mismatch;
    logic [1:0]       match_inc, err_inc;

    // Saturating add of 0..2 events onto a counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W - 1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Per-lane accept/flush/compare decode, gated by the registered stall.
    always_comb begin
        flush_1   = in_flush_1 & ~global_stall;
        flush_2   = in_flush_2 & ~global_stall;
        acc_1     = in_valid_1 & ~global_stall & ~in_flush_1;
        acc_2     = in_valid_2 & ~global_stall & ~in_flush_2;
        match_1   = acc_1 & (resync_1 | (in_data_1 == exp_1));
        match_2   = acc_2 & (resync_2 | (in_data_2 == exp_2));
        err_1     = acc_1 & ~resync_1 & (in_data_1 != exp_1);
        err_2     = acc_2 & ~resync_2 & (in_data_2 != exp_2);
        mismatch  = err_1 | err_2;
        match_inc = {1'b0, match_1} + {1'b0, match_2};
        err_inc   = {1'b0, err_1} + {1'b0, err_2};
    end

    // Next-state logic: halt beats stall in RUN; STALL counts down to RUN.
    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        case (state)
            ST_RUN: begin
                if (mismatch && halt_on_error) begin
                    state_nxt = ST_HALT;
                end else if (stall_en && ({1'b0, lfsr[3:0]} < THRESH)) begin
                    state_nxt     = ST_STALL;
                    stall_cnt_nxt = {1'b0, lfsr[6:4]} + 4'd1;
                end
            end
            ST_STALL: begin
                if (stall_cnt <= 4'd1) begin
                    state_nxt     = ST_RUN;
                    stall_cnt_nxt = 4'd0;
                end else begin
                    stall_cnt_nxt = stall_cnt - 4'd1;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt     = ST_RUN;
                stall_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State, LFSR and registered stall/halt outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            stall_cnt    <= 4'd0;
            lfsr         <= LFSR_SEED;
            global_stall <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_nxt;
            stall_cnt    <= stall_cnt_nxt;
            lfsr         <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            global_stall <= (state_nxt != ST_RUN);
            halted       <= (state_nxt == ST_HALT);
        end
    end

    // Expected-value tracking and resync flags for both lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_1    <= WIDTH'(1);
            exp_2    <= WIDTH'(2);
            resync_1 <= 1'b0;
            resync_2 <= 1'b0;
        end else begin
            if (flush_1) begin
                resync_1 <= 1'b1;
            end else if (acc_1) begin
                exp_1    <= in_data_1 + WIDTH'(1);
                resync_1 <= 1'b0;
            end
            if (flush_2) begin
                resync_2 <= 1'b1;
            end else if (acc_2) begin
                exp_2    <= in_data_2 + WIDTH'(1);
                resync_2 <= 1'b0;
            end
        end
    end

    // Saturating match/error counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
            err_count   <= '0;
            error_flag  <= 1'b0;
        end else begin
            match_count <= sat_add(match_count, match_inc);
            err_count   <= sat_add(err_count, err_inc);
            if (mismatch) begin
                error_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_consumer_fsm.sv
// tb/tb_pipeline_consumer_fsm.sv - self-checking bench for pipeline_consumer_fsm
module tb_pipeline_consumer_fsm;

    localparam int W      = 32;
    localparam int CW     = 16;
    localparam int THRESH = 16;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  in_data_1 = '0, in_data_2 = '0;
    logic          in_valid_1 = 1'b0, in_valid_2 = 1'b0;
    logic          in_flush_1 = 1'b0, in_flush_2 = 1'b0;
    logic          stall_en = 1'b0, halt_on_error = 1'b0;
    logic          global_stall, error_flag, halted;
    logic [CW-1:0] match_count, err_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_stall, m_halt, m_ef;
    int          m_left, m_mc, m_ec;
    logic [15:0] m_lfsr;
    logic [W-1:0] m_exp1, m_exp2;
    bit          m_rs1, m_rs2;

    pipeline_consumer_fsm #(
        .WIDTH(W), .LFSR_SEED(16'hACE1), .STALL_THRESH(THRESH), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data_1(in_data_1), .in_valid_1(in_valid_1), .in_flush_1(in_flush_1),
        .in_data_2(in_data_2), .in_valid_2(in_valid_2), .in_flush_2(in_flush_2),
        .stall_en(stall_en), .halt_on_error(halt_on_error),
        .global_stall(global_stall), .match_count(match_count), .err_count(err_count),
        .error_flag(error_flag), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic lane(input logic v, input logic f, input logic [W-1:0] d,
                        inout logic [W-1:0] e, inout bit rs, output bit bad);
        bad = 0;
        if (f) begin
            rs = 1;
        end else if (v) begin
            if (rs || d == e) m_mc = sat(m_mc, 1);
            else begin
                m_ec = sat(m_ec, 1);
                m_ef = 1;
                bad  = 1;
            end
            rs = 0;
            e  = d + 1;
        end
    endtask

    // One clock edge of the behavioural model, using inputs sampled at that edge.
    task automatic model_step();
        bit b1, b2;
        logic [15:0] l;
        if (reset) begin
            m_stall = 0; m_halt = 0; m_left = 0; m_ef = 0; m_mc = 0; m_ec = 0;
            m_lfsr = 16'hACE1; m_exp1 = 1; m_exp2 = 2; m_rs1 = 0; m_rs2 = 0;
            return;
        end
        b1 = 0; b2 = 0;
        if (!m_stall) begin
            lane(in_valid_1, in_flush_1, in_data_1, m_exp1, m_rs1, b1);
            lane(in_valid_2, in_flush_2, in_data_2, m_exp2, m_rs2, b2);
        end
        l = m_lfsr;
        if (m_halt) begin
            m_stall = 1;
        end else if (m_stall) begin
            m_left--;
            if (m_left == 0) m_stall = 0;
        end else if ((b1 || b2) && halt_on_error) begin
            m_halt = 1; m_stall = 1;
        end else if (stall_en && int'(l[3:0]) < THRESH) begin
            m_stall = 1;
            m_left  = int'(l[6:4]) + 1;
        end
        m_lfsr = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("global_stall", 64'(global_stall), 64'(m_stall));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("match_count", 64'(match_count), 64'(m_mc));
        chk("err_count", 64'(err_count), 64'(m_ec));
        chk("error_flag", 64'(error_flag), 64'(m_ef));
    endtask

    task automatic beat(input logic v1, input logic [W-1:0] a, input logic v2, input logic [W-1:0] b);
        in_valid_1 = v1; in_data_1 = a; in_flush_1 = 0;
        in_valid_2 = v2; in_data_2 = b; in_flush_2 = 0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1;
        beat(0, 0, 0, 0);
        beat(0, 0, 0, 0);
        reset = 0;
    endtask

    initial begin
        int burst, run_len;
        bit seen;
        // Reset behaviour
        do_reset();
        chk("rst_match", 64'(match_count), 0);
        chk("rst_err", 64'(err_count), 0);
        chk("rst_stall", 64'(global_stall), 0);
        chk("rst_halted", 64'(halted), 0);
        for (int i = 0; i < 5; i++) begin
            beat(0, 0, 0, 0);
            chk("idle_stall", 64'(global_stall), 0);
        end

        // In-order stream on both lanes
        beat(1, 1, 1, 2); beat(1, 2, 1, 3); beat(1, 3, 1, 4); beat(0, 0, 0, 0);
        chk("inorder_match", 64'(match_count), 6);
        chk("inorder_err", 64'(err_count), 0);
        chk("inorder_flag", 64'(error_flag), 0);

        // Mismatch and resync
        do_reset();
        beat(1, 1, 1, 2); beat(1, 7, 1, 3); beat(1, 8, 1, 4); beat(0, 0, 0, 0);
        chk("mm_err", 64'(err_count), 1);
        chk("mm_match", 64'(match_count), 5);
        chk("mm_flag", 64'(error_flag), 1);
        chk("mm_halted", 64'(halted), 0);

        // Flush with valid: discarded, then resync
        do_reset();
        beat(1, 1, 1, 2);
        in_flush_1 = 1; in_valid_1 = 1; in_data_1 = 99; in_valid_2 = 0;
        tick();
        beat(1, 50, 0, 0); beat(1, 51, 0, 0); beat(0, 0, 0, 0);
        chk("flush_match", 64'(match_count), 4);
        chk("flush_err", 64'(err_count), 0);

        // Expected value wraps past all-ones without error
        do_reset();
        in_flush_1 = 1; in_valid_1 = 0;
        tick();
        beat(1, 32'hFFFF_FFFF, 0, 0); beat(1, 0, 0, 0); beat(0, 0, 0, 0);
        chk("wrap_match", 64'(match_count), 2);
        chk("wrap_err", 64'(err_count), 0);

        // Halt on a lane-2 mismatch
        do_reset();
        halt_on_error = 1;
        beat(1, 1, 1, 5);
        chk("halt_stall", 64'(global_stall), 1);
        chk("halt_halted", 64'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            beat(1, W'($urandom), 1, W'($urandom));
            chk("halt_hold", 64'(halted), 1);
            chk("halt_match_frozen", 64'(match_count), 1);
            chk("halt_err_frozen", 64'(err_count), 1);
        end
        do_reset();
        chk("halt_rst_stall", 64'(global_stall), 0);
        chk("halt_rst_halted", 64'(halted), 0);
        halt_on_error = 0;

        // Random back-pressure with mostly in-order data
        stall_en = 1;
        burst = 0; run_len = 0; seen = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid_1 = ($urandom_range(0, 3) != 0);
            in_valid_2 = ($urandom_range(0, 3) != 0);
            in_flush_1 = ($urandom_range(0, 15) == 0);
            in_flush_2 = ($urandom_range(0, 15) == 0);
            in_data_1  = ($urandom_range(0, 7) != 0) ? m_exp1 : W'($urandom);
            in_data_2  = ($urandom_range(0, 7) != 0) ? m_exp2 : W'($urandom);
            tick();
            if (global_stall) begin
                if (seen && run_len > 0) chk("run_gap", 64'(run_len), 1);
                run_len = 0;
                burst++;
            end else begin
                if (burst > 0) begin
                    n_cmp++;
                    assert (burst >= 1 && burst <= 8) else begin
                        n_err++;
                        $error("FAIL burst_len observed=%0d expected=1..8", burst);
                    end
                    seen = 1;
                end
                burst = 0;
                run_len++;
            end
        end

        // Random mix including halts and resets
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            stall_en      = ($urandom_range(0, 1) != 0);
            halt_on_error = ($urandom_range(0, 7) == 0);
            in_valid_1 = $urandom_range(0, 1);
            in_valid_2 = $urandom_range(0, 1);
            in_flush_1 = ($urandom_range(0, 15) == 0);
            in_flush_2 = ($urandom_range(0, 15) == 0);
            in_data_1  = ($urandom_range(0, 7) != 0) ? m_exp1 : W'($urandom);
            in_data_2  = ($urandom_range(0, 7) != 0) ? m_exp2 : W'($urandom);
            tick();
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
